// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: two-stage valid/ready 8-bit barrel shifter (SLL/SRL/SRA/ROL)
module barrel_shift_pipe #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [1:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data
);
  logic             a_valid_q, a_valid_d, a_hi_q, a_hi_d, b_valid_q, b_valid_d;
  logic [WIDTH-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
  logic [1:0]       a_op_q, a_op_d;
  logic             b_adv, a_adv, accept;

  // One mux layer: conditionally shift v by n using op; SRA refills from the current bit 7,
  // which every earlier layer has preserved, so it is always the operand's original sign.
  function automatic logic [WIDTH-1:0] layer(input logic [WIDTH-1:0] v, input logic [1:0] op,
                                             input logic en, input int n);
    logic [WIDTH-1:0] sra, rol;
    sra = $signed(v) >>> n;
    rol = (v << n) | (v >> (WIDTH - n));
    return !en ? v : op == 2'b00 ? v << n : op == 2'b01 ? v >> n : op == 2'b10 ? sra : rol;
  endfunction

  // Handshake and next-state: data registers only load on real transfers so X on idle inputs never enters
  always_comb begin
    b_adv     = !b_valid_q || out_ready;
    a_adv     = !a_valid_q || b_adv;
    accept    = in_valid && a_adv;
    a_valid_d = a_adv ? in_valid : a_valid_q;
    a_data_d  = accept ? layer(layer(in_data, in_op, in_shamt[0], 1), in_op, in_shamt[1], 2) : a_data_q;
    a_hi_d    = accept ? in_shamt[2] : a_hi_q;
    a_op_d    = accept ? in_op : a_op_q;
    b_valid_d = b_adv ? a_valid_q : b_valid_q;
    b_data_d  = (b_adv && a_valid_q) ? layer(a_data_q, a_op_q, a_hi_q, 4) : b_data_q;
  end

  // Pipeline registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
      a_hi_q    <= 1'b0;
      a_op_q    <= '0;
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_data_q  <= a_data_d;
      a_hi_q    <= a_hi_d;
      a_op_q    <= a_op_d;
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
    end
  end

  assign in_ready  = a_adv;
  assign out_valid = b_valid_q;
  assign out_data  = b_data_q;
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb_barrel_shift_pipe: directed and randomized checks of barrel_shift_pipe against a shift model
module tb_barrel_shift_pipe;
  logic       clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [2:0] in_shamt;
  logic [1:0] in_op;
  int errors = 0;
  int checks = 0;

  barrel_shift_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s, input logic [1:0] op);
    logic [15:0] t;
    logic [7:0]  r;
    t = {d, d} << s;
    r = $signed(d) >>> s;
    case (op)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return r;
      default: return t[15:8];
    endcase
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_data  = 'x;
    in_shamt = 'x;
    in_op    = 'x;
  endtask

  task automatic send_one(input logic [7:0] d, input logic [2:0] s, input logic [1:0] op, input logic [7:0] exp);
    in_valid = 1'b1; in_data = d; in_shamt = s; in_op = op; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL send_ready: in_ready=%b want 1", in_ready); end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL send_early: out_valid=%b want 0 one cycle after accept", out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp) begin
      errors++;
      $display("FAIL send_result d=%h s=%0d op=%0d: valid=%b data=%h want 1/%h", d, s, op, out_valid, out_data, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h ready=%b want 0/00/1", out_valid, out_data, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_release: out_valid=%b want 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_ops();
    send_one(8'hB5, 3'd3, 2'b00, 8'hA8);
    send_one(8'hB5, 3'd3, 2'b01, 8'h16);
    send_one(8'hB5, 3'd3, 2'b10, 8'hF6);
    send_one(8'hB5, 3'd3, 2'b11, 8'hAD);
  endtask

  task automatic test_edges();
    send_one(8'h80, 3'd0, 2'b10, 8'h80);
    send_one(8'h80, 3'd7, 2'b10, 8'hFF);
    send_one(8'h80, 3'd7, 2'b01, 8'h01);
    send_one(8'h01, 3'd7, 2'b11, 8'h80);
  endtask

  task automatic test_back_to_back();
    logic [7:0] one;
    one = 8'h01;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        in_valid = 1'b1; in_data = 8'h01; in_shamt = 3'(i); in_op = 2'b00;
      end else idle_inputs();
      @(negedge clk);
      if (i < 8) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: in_ready=%b want 1", i, in_ready); end
      end
      if (i >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== (one << (i - 2))) begin
          errors++;
          $display("FAIL b2b_out[%0d]: valid=%b data=%h want 1/%h", i - 2, out_valid, out_data, one << (i - 2));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h11; in_shamt = 3'd1; in_op = 2'b00;
    @(posedge clk); #1;
    in_data = 8'h33; in_shamt = 3'd1; in_op = 2'b01;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_data = 8'h44; in_shamt = 3'd2; in_op = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h22 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall[%0d]: valid=%b data=%h ready=%b want 1/22/0", i, out_valid, out_data, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h22 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b data=%h ready=%b want 1/22/1", out_valid, out_data, in_ready);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h19) begin
      errors++; $display("FAIL bp_drain2: valid=%b data=%h want 1/19", out_valid, out_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      errors++; $display("FAIL bp_drain3: valid=%b data=%h want 1/11", out_valid, out_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: out_valid=%b want 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h5A; in_shamt = 3'd1; in_op = 2'b00;
    @(posedge clk); #1;
    in_data = 8'hC3; in_shamt = 3'd2; in_op = 2'b10;
    @(posedge clk); #1;
    out_ready = 1'b0;
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: valid=%b data=%h ready=%b want 0/00/1", out_valid, out_data, in_ready);
    end
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale[%0d]: out_valid=%b want 0", i, out_valid); end
      @(posedge clk); #1;
    end
    send_one(8'h3C, 3'd4, 2'b11, 8'hC3);
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] exp, held;
    logic       stall;
    int         sent, got, cyc;
    sent = 0; got = 0; cyc = 0; stall = 1'b0; held = '0;
    while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
      if (sent < 1000 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; in_data = 8'($urandom); in_shamt = 3'($urandom); in_op = 2'($urandom);
      end else idle_inputs();
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          errors++; $display("FAIL rnd_hold: valid=%b data=%h want 1/%h", out_valid, out_data, held);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_extra: unexpected result %h", out_data);
        end else begin
          exp = q.pop_front();
          got++;
          if (out_data !== exp) begin errors++; $display("FAIL rnd_data[%0d]: data=%h want %h", got, out_data, exp); end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        q.push_back(ref_shift(in_data, in_shamt, in_op));
        sent++;
      end
      stall = (out_valid === 1'b1) && !out_ready;
      held = out_data;
      @(posedge clk); #1;
      cyc++;
    end
    idle_inputs();
    checks++;
    if (sent != 1000 || got != 1000 || q.size() != 0) begin
      errors++; $display("FAIL rnd_count: sent=%0d got=%0d pending=%0d want 1000/1000/0", sent, got, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_edges();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
